// File: rtl/autosa_csb_initiator.sv
// CSB initiator: converts single host register commands into 63-bit CSB requests,
// waits for the 34-bit response (or a timeout) and returns a one-cycle completion.
module autosa_csb_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 autosa_core_clk,
  input  logic                 autosa_core_rstn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic                 cmd_nposted,
  input  logic [21:0]          cmd_addr,
  input  logic [31:0]          cmd_wdat,
  output logic                 csb_req_pvld,
  input  logic                 csb_req_prdy,
  output logic [62:0]          csb_req_pd,
  input  logic                 csb_resp_valid,
  input  logic [33:0]          csb_resp_pd,
  output logic                 done_valid,
  output logic [31:0]          done_rdata,
  output logic                 done_error,
  output logic                 done_timeout,
  output logic                 spurious_rsp
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REQ_W  = 63;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [REQ_W-1:0]   req_pd_d;
  logic               pvld_d, cmd_ready_d, done_valid_d;
  logic [DATA_W-1:0]  done_rdata_d;
  logic               done_error_d, done_timeout_d, spurious_d;
  logic               cur_write, cur_nposted, rsp_err;

  assign cur_write   = csb_req_pd[54];
  assign cur_nposted = csb_req_pd[55];
  assign rsp_err     = csb_resp_pd[32] | (csb_resp_pd[33] != cur_write);

  // State and all registered outputs
  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state        <= S_IDLE;
      cnt          <= '0;
      csb_req_pd   <= '0;
      csb_req_pvld <= 1'b0;
      cmd_ready    <= 1'b1;
      done_valid   <= 1'b0;
      done_rdata   <= '0;
      done_error   <= 1'b0;
      done_timeout <= 1'b0;
      spurious_rsp <= 1'b0;
    end else begin
      state        <= next_state;
      cnt          <= cnt_d;
      csb_req_pd   <= req_pd_d;
      csb_req_pvld <= pvld_d;
      cmd_ready    <= cmd_ready_d;
      done_valid   <= done_valid_d;
      done_rdata   <= done_rdata_d;
      done_error   <= done_error_d;
      done_timeout <= done_timeout_d;
      spurious_rsp <= spurious_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (cmd_valid) next_state = S_REQ;
      S_REQ: begin
        if (csb_req_prdy) begin
          if (cur_write && !cur_nposted) next_state = S_DONE;
          else                           next_state = S_WAIT;
        end
      end
      S_WAIT: if (csb_resp_valid || (cnt == CNT_LAST)) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; done_* hold until the next completion
  always_comb begin
    req_pd_d       = csb_req_pd;
    cnt_d          = cnt;
    pvld_d         = (next_state == S_REQ);
    cmd_ready_d    = (next_state == S_IDLE);
    done_valid_d   = 1'b0;
    done_rdata_d   = done_rdata;
    done_error_d   = done_error;
    done_timeout_d = done_timeout;
    spurious_d     = csb_resp_valid && (state != S_WAIT);
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          req_pd_d = {2'b00, 4'hF, 1'b0,
                      cmd_write & cmd_nposted,
                      cmd_write,
                      cmd_write ? cmd_wdat : 32'h0,
                      cmd_addr};
        end
      end
      S_REQ: begin
        if (csb_req_prdy) begin
          cnt_d = '0;
          if (cur_write && !cur_nposted) begin
            done_valid_d   = 1'b1;
            done_rdata_d   = '0;
            done_error_d   = 1'b0;
            done_timeout_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        if (csb_resp_valid) begin
          done_valid_d   = 1'b1;
          done_error_d   = rsp_err;
          done_timeout_d = 1'b0;
          done_rdata_d   = (!cur_write && !rsp_err) ? csb_resp_pd[31:0] : 32'h0;
        end else if (cnt == CNT_LAST) begin
          done_valid_d   = 1'b1;
          done_error_d   = 1'b1;
          done_timeout_d = 1'b1;
          done_rdata_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_autosa_csb_initiator.sv
// Directed self-checking bench for autosa_csb_initiator (TIMEOUT_CYCLES = 4).
module tb_autosa_csb_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_nposted;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic        csb_req_pvld, csb_req_prdy;
  logic [62:0] csb_req_pd;
  logic        csb_resp_valid;
  logic [33:0] csb_resp_pd;
  logic        done_valid, done_error, done_timeout, spurious_rsp;
  logic [31:0] done_rdata;

  int checks = 0;
  int errors = 0;

  autosa_csb_initiator #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_nposted     (cmd_nposted),
    .cmd_addr        (cmd_addr),
    .cmd_wdat        (cmd_wdat),
    .csb_req_pvld    (csb_req_pvld),
    .csb_req_prdy    (csb_req_prdy),
    .csb_req_pd      (csb_req_pd),
    .csb_resp_valid  (csb_resp_valid),
    .csb_resp_pd     (csb_resp_pd),
    .done_valid      (done_valid),
    .done_rdata      (done_rdata),
    .done_error      (done_error),
    .done_timeout    (done_timeout),
    .spurious_rsp    (spurious_rsp)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle (cmd_ready is 1 in IDLE), leaving the bench in cycle N+1
  task automatic issue(input logic wr, input logic np, input logic [21:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_nposted = np; cmd_addr = a; cmd_wdat = d;
    step();
    cmd_valid = 1'b0;
  endtask

  // One-cycle response pulse in the current cycle
  task automatic respond(input logic [33:0] pd);
    csb_resp_valid = 1'b1; csb_resp_pd = pd;
    step();
    csb_resp_valid = 1'b0; csb_resp_pd = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    checks++;
    if ({csb_req_pvld, csb_req_pd, cmd_ready, done_valid, done_rdata, done_error, done_timeout, spurious_rsp}
        !== {1'b0, 63'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals pvld=%b pd=%h rdy=%b dv=%b rd=%h er=%b to=%b sp=%b (want 0 0 1 0 0 0 0 0)",
               csb_req_pvld, csb_req_pd, cmd_ready, done_valid, done_rdata, done_error, done_timeout, spurious_rsp);
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_read();
    logic [62:0] exp_pd;
    exp_pd = {2'b00, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 22'h000010};
    issue(1'b0, 1'b1, 22'h000010, 32'hFFFF_FFFF);   // N+1
    checks++;
    if (csb_req_pvld !== 1'b1 || csb_req_pd !== exp_pd) begin
      errors++; $display("FAIL read_req pvld=%b pd=%h want 1 %h", csb_req_pvld, csb_req_pd, exp_pd);
    end
    step();                                          // N+2
    checks++;
    if (csb_req_pvld !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL read_wait pvld=%b dv=%b want 0 0", csb_req_pvld, done_valid);
    end
    step();                                          // N+3
    respond({1'b0, 1'b0, 32'hDEADBEEF});             // N+4
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout, cmd_ready} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL read_done dv=%b rd=%h er=%b to=%b rdy=%b want 1 deadbeef 0 0 0",
                         done_valid, done_rdata, done_error, done_timeout, cmd_ready);
    end
    step();                                          // N+5
    checks++;
    if (done_valid !== 1'b0 || cmd_ready !== 1'b1 || done_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_after dv=%b rdy=%b rd=%h want 0 1 deadbeef", done_valid, cmd_ready, done_rdata);
    end
  endtask

  task automatic test_posted_write();
    logic [62:0] exp_pd;
    exp_pd = {2'b00, 4'hF, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A, 22'h4};
    issue(1'b1, 1'b0, 22'h4, 32'h5A5A5A5A);          // N+1
    checks++;
    if (csb_req_pvld !== 1'b1 || csb_req_pd !== exp_pd) begin
      errors++; $display("FAIL pw_req pvld=%b pd=%h want 1 %h", csb_req_pvld, csb_req_pd, exp_pd);
    end
    step();                                          // N+2
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL pw_done dv=%b rd=%h er=%b to=%b want 1 0 0 0", done_valid, done_rdata, done_error, done_timeout);
    end
    step();                                          // N+3
    checks++;
    if (cmd_ready !== 1'b1 || done_valid !== 1'b0) begin
      errors++; $display("FAIL pw_ready rdy=%b dv=%b want 1 0", cmd_ready, done_valid);
    end
  endtask

  task automatic test_stall_nposted();
    logic [62:0] exp_pd;
    exp_pd = {2'b00, 4'hF, 1'b0, 1'b1, 1'b1, 32'hCAFE0001, 22'h2ABCDE};
    csb_req_prdy = 1'b0;
    issue(1'b1, 1'b1, 22'h2ABCDE, 32'hCAFE0001);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (csb_req_pvld !== 1'b1 || csb_req_pd !== exp_pd) begin
        errors++; $display("FAIL stall_pd[%0d] pvld=%b pd=%h want 1 %h", i, csb_req_pvld, csb_req_pd, exp_pd);
      end
      step();
    end
    csb_req_prdy = 1'b1;
    step();                                          // WAIT
    checks++;
    if (csb_req_pvld !== 1'b0 || done_valid !== 1'b0) begin
      errors++; $display("FAIL stall_wait pvld=%b dv=%b want 0 0", csb_req_pvld, done_valid);
    end
    respond({1'b1, 1'b1, 32'h12345678});
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL np_err dv=%b rd=%h er=%b to=%b want 1 0 1 0", done_valid, done_rdata, done_error, done_timeout);
    end
    step();
  endtask

  task automatic test_timeout();
    issue(1'b0, 1'b0, 22'h000020, 32'h0);            // H (handshake)
    for (int i = 1; i <= 4; i++) begin
      step();                                        // H+i
      checks++;
      if (done_valid !== 1'b0) begin
        errors++; $display("FAIL to_early[%0d] dv=%b want 0", i, done_valid);
      end
    end
    step();                                          // H+5
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL to_done dv=%b rd=%h er=%b to=%b want 1 0 1 1", done_valid, done_rdata, done_error, done_timeout);
    end
    step();                                          // H+6
    step();                                          // H+7
    respond({1'b0, 1'b0, 32'h11112222});             // H+8
    checks++;
    if (spurious_rsp !== 1'b1 || done_valid !== 1'b0 || done_timeout !== 1'b1) begin
      errors++; $display("FAIL late_rsp sp=%b dv=%b to=%b want 1 0 1", spurious_rsp, done_valid, done_timeout);
    end
    step();
    checks++;
    if (spurious_rsp !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL late_after sp=%b rdy=%b want 0 1", spurious_rsp, cmd_ready);
    end
  endtask

  task automatic test_type_mismatch();
    issue(1'b0, 1'b0, 22'h000030, 32'h0);
    step();
    respond({1'b1, 1'b0, 32'hA5A5A5A5});
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mismatch dv=%b rd=%h er=%b to=%b want 1 0 1 0", done_valid, done_rdata, done_error, done_timeout);
    end
    step();
  endtask

  task automatic test_last_cycle_rsp();
    issue(1'b0, 1'b0, 22'h000040, 32'h0);            // H
    for (int i = 0; i < 4; i++) step();              // H+4, counter at last value
    respond({1'b0, 1'b0, 32'h0BADF00D});             // H+5
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout} !== {1'b1, 32'h0BADF00D, 1'b0, 1'b0}) begin
      errors++; $display("FAIL last_cycle dv=%b rd=%h er=%b to=%b want 1 0badf00d 0 0", done_valid, done_rdata, done_error, done_timeout);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    issue(1'b0, 1'b0, 22'h000050, 32'h0);
    step();                                          // WAIT
    rstn = 1'b0;
    step();
    checks++;
    if ({csb_req_pvld, csb_req_pd, cmd_ready, done_valid, done_rdata, done_error, done_timeout, spurious_rsp}
        !== {1'b0, 63'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_wait pvld=%b pd=%h rdy=%b dv=%b rd=%h er=%b to=%b sp=%b (want 0 0 1 0 0 0 0 0)",
               csb_req_pvld, csb_req_pd, cmd_ready, done_valid, done_rdata, done_error, done_timeout, spurious_rsp);
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++; $display("FAIL rst_nodone[%0d] dv=%b rdy=%b want 0 1", i, done_valid, cmd_ready);
      end
    end
    issue(1'b0, 1'b0, 22'h000060, 32'h0);
    step();
    step();
    respond({1'b0, 1'b0, 32'h600D600D});
    checks++;
    if ({done_valid, done_rdata, done_error, done_timeout} !== {1'b1, 32'h600D600D, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_fresh dv=%b rd=%h er=%b to=%b want 1 600d600d 0 0", done_valid, done_rdata, done_error, done_timeout);
    end
    step();
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_nposted = 1'b0; cmd_addr = '0; cmd_wdat = '0;
    csb_req_prdy = 1'b1; csb_resp_valid = 1'b0; csb_resp_pd = '0;
    #2;
    test_reset();
    test_read();
    test_posted_write();
    test_stall_nposted();
    test_timeout();
    test_type_mismatch();
    test_last_cycle_rsp();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
